// File: rtl/pdm_decoder_pkg.sv
// Shared definitions for the PDM decoder: CIC width rule, FSM states and the
// number of decimation events discarded while the comb pipeline fills.
package pdm_decoder_pkg;

    // Events discarded after reset before the comb output is meaningful.
    localparam int FILL_DISCARD = 2;
    localparam int FILL_CNT_W   = 2;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A sinc2 stage with decimation R = 2^dec_log2 has gain R^2, so the
    // datapath needs 2*dec_log2 + 1 bits to hold the full-scale value R^2.
    function automatic int cic_width(input int dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/cic_sinc2_decimator.sv
// Second-order CIC decimator: two integrators running at the PDM bit rate,
// a decimation counter, and a two-stage comb evaluated on the event cycle.
// y_o is valid (combinationally) only while evt_o is high.
module cic_sinc2_decimator
    import pdm_decoder_pkg::*;
#(
    parameter int DECIMATION_LOG2 = 5,
    parameter int W               = cic_width(DECIMATION_LOG2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din_en_i,
    input  logic         din_i,
    output logic [W-1:0] y_o,
    output logic         evt_o
);

    logic [W-1:0]               int1_q, int1_d;
    logic [W-1:0]               int2_q, int2_d;
    logic [W-1:0]               d1_q, d1_d;
    logic [W-1:0]               d2_q, d2_d;
    logic [W-1:0]               c1;
    logic [DECIMATION_LOG2-1:0] cnt_q, cnt_d;

    // Integrate, count and run the comb on the decimation event; all sums wrap mod 2^W.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so later lines see updated values and no latch appears.
        int1_d = int1_q;
        int2_d = int2_q;
        cnt_d  = cnt_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        evt_o  = 1'b0;
        if (din_en_i) begin
            int1_d = int1_q + {{(W-1){1'b0}}, din_i};
            int2_d = int2_q + int1_q;
            cnt_d  = cnt_q + DECIMATION_LOG2'(1);
            evt_o  = (cnt_q == '1);
        end
        // The comb sees the value int2 takes on this very edge.
        c1  = int2_d - d1_q;
        y_o = c1 - d2_q;
        if (evt_o) begin
            d1_d = int2_d;
            d2_d = c1;
        end
    end

    // Integrator, counter and comb-delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' and every register is
        // cleared by the async reset so simulation and silicon start identical.
        if (!rst_n) begin
            int1_q <= '0;
            int2_q <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            cnt_q  <= '0;
        end else begin
            int1_q <= int1_d;
            int2_q <= int2_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pdm_decoder.sv
// PDM-to-PCM decoder: sinc2 decimator, scale/clamp to DATA_BITS, a FILL/RUN
// FSM that drops the start-up transient, and a one-entry valid/ready output.
module pdm_decoder
    import pdm_decoder_pkg::*;
#(
    parameter int DATA_BITS       = 8,
    parameter int DECIMATION_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overrun
);

    localparam int W     = cic_width(DECIMATION_LOG2);
    localparam int SHIFT = 2 * DECIMATION_LOG2 - DATA_BITS;
    localparam logic [W-1:0] SAMPLE_MAX = W'((2 ** DATA_BITS) - 1);

    logic [W-1:0]          cic_y;
    logic                  cic_evt;
    logic [W-1:0]          y_shift;
    logic [DATA_BITS-1:0]  sample;

    state_e                state_q, state_d;
    logic [FILL_CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic                  load;

    logic [DATA_BITS-1:0]  dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    cic_sinc2_decimator #(
        .DECIMATION_LOG2 (DECIMATION_LOG2),
        .W               (W)
    ) u_cic (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_en_i (din_en),
        .din_i    (din),
        .y_o      (cic_y),
        .evt_o    (cic_evt)
    );

    // Scale to DATA_BITS; only the all-ones input (y = R^2) exceeds the range.
    always_comb begin
        y_shift = cic_y >> SHIFT;
        if (y_shift > SAMPLE_MAX) begin
            sample = '1;
        end else begin
            sample = y_shift[DATA_BITS-1:0];
        end
    end

    // FSM next state: discard the first events after reset, then pass every event.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        load       = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (cic_evt) begin
                    fill_cnt_d = fill_cnt_q + FILL_CNT_W'(1);
                    if (fill_cnt_q == FILL_CNT_W'(FILL_DISCARD - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                load = cic_evt;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Output register next state: a new sample always wins; overrun is sticky.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            dout_d  = sample;
            valid_d = 1'b1;
            if (valid_q && !dout_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Bench for pdm_decoder: randomized PDM stimulus against a reference that
// evaluates the sinc2 response directly from the recorded bit history.
module tb_pdm_decoder;

    localparam int DATA_BITS = 8;
    localparam int DEC_LOG2  = 5;
    localparam int R         = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 din_en;
    logic                 din;
    logic                 dout_ready;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 overrun;

    pdm_decoder #(
        .DATA_BITS       (DATA_BITS),
        .DECIMATION_LOG2 (DEC_LOG2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_en     (din_en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: consumed bits since reset and the expected output register.
    bit                   hist[$];
    int                   ev_cnt;
    logic [DATA_BITS-1:0] m_dout;
    bit                   m_valid;
    bit                   m_overrun;
    int                   cyc;
    int                   first_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Double integral of the first n bits: bit i is summed into n-1-i partial sums.
    function automatic int integ2(input int n);
        int acc = 0;
        for (int i = 0; i < n; i++) acc += int'(hist[i]) * (n - 1 - i);
        return acc;
    endfunction

    // Second difference of the double integral at decimation points k, k-1, k-2.
    function automatic int sinc2(input int k);
        int a = integ2(R * k);
        int b = (k >= 1) ? integ2(R * (k - 1)) : 0;
        int c = (k >= 2) ? integ2(R * (k - 2)) : 0;
        return a - 2 * b + c;
    endfunction

    function automatic logic [DATA_BITS-1:0] scale(input int y);
        int s = y / (2 ** (2 * DEC_LOG2 - DATA_BITS));
        if (s > 2 ** DATA_BITS - 1) s = 2 ** DATA_BITS - 1;
        return DATA_BITS'(s);
    endfunction

    // pat: 0 zeros, 1 ones, 2 alternating 1/0, 3 1110, 4 random
    function automatic bit pattern_bit(input int pat, input int idx);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (idx % 2) == 0;
            3:       return (idx % 4) != 3;
            default: return 1'($urandom_range(1, 0));
        endcase
    endfunction

    // Pulse reset at a negedge, check outputs clear asynchronously, then release.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout), 32'h0);
        check("async_rst_valid", 32'(dout_valid), 32'h0);
        check("async_rst_overrun", 32'(overrun), 32'h0);
        hist.delete();
        ev_cnt      = 0;
        m_dout      = '0;
        m_valid     = 1'b0;
        m_overrun   = 1'b0;
        cyc         = 0;
        first_valid = -1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, advance the reference, compare 1 ns after posedge.
    // en_mode: 0 always, 1 every 4th clock, 2 random; rdy_mode: 0 high, 1 low, 2 random.
    task automatic step(input int en_mode, input int pat, input int rdy_mode);
        bit                   load;
        logic [DATA_BITS-1:0] smp;
        case (en_mode)
            0:       din_en = 1'b1;
            1:       din_en = (cyc % 4) == 0;
            default: din_en = 1'($urandom_range(1, 0));
        endcase
        din = din_en ? pattern_bit(pat, hist.size()) : 1'($urandom_range(1, 0));
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = 1'b0;
            default: dout_ready = 1'($urandom_range(1, 0));
        endcase

        load = 1'b0;
        smp  = '0;
        if (din_en) begin
            hist.push_back(din);
            if (hist.size() % R == 0) begin
                ev_cnt++;
                if (ev_cnt > 2) begin
                    load = 1'b1;
                    smp  = scale(sinc2(ev_cnt));
                end
            end
        end
        if (load) begin
            if (m_valid && !dout_ready) m_overrun = 1'b1;
            m_dout  = smp;
            m_valid = 1'b1;
        end else if (m_valid && dout_ready) begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_overrun));
        check("dout", 32'(dout), 32'(m_dout));
        if (first_valid < 0 && dout_valid) first_valid = cyc;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        din_en     = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b1;
        cyc        = 0;
        first_valid = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Constant zeros.
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 0, 0);
        check("zeros_first_valid", 32'(first_valid), 32'd96);
        check("zeros_dout", 32'(dout), 32'h00);

        // Constant ones: first sample one clock after the 3rd event, clamped.
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 1, 0);
        check("ones_first_valid", 32'(first_valid), 32'd96);
        check("ones_dout", 32'(dout), 32'hFF);

        // 50 % and 75 % density.
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 2, 0);
        check("alt_dout", 32'(dout), 32'h80);
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 3, 0);
        check("d75_dout", 32'(dout), 32'hC0);

        // Bit strobe every 4th clock: 96th consumed bit is on clock index 380.
        do_reset();
        for (int i = 0; i < 600; i++) step(1, 1, 0);
        check("slow_first_valid", 32'(first_valid), 32'd381);
        check("slow_dout", 32'(dout), 32'hFF);

        // Consumer stalled across several events, then released.
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 2, 1);
        check("stall_overrun", 32'(overrun), 32'h1);
        check("stall_valid", 32'(dout_valid), 32'h1);
        step(0, 2, 0);
        check("release_valid", 32'(dout_valid), 32'h0);
        check("release_overrun", 32'(overrun), 32'h1);

        // Reset mid-window with ones: full FILL sequence again.
        do_reset();
        for (int i = 0; i < 150; i++) step(0, 1, 0);
        do_reset();
        for (int i = 0; i < 130; i++) step(0, 1, 0);
        check("rerst_first_valid", 32'(first_valid), 32'd96);
        check("rerst_dout", 32'(dout), 32'hFF);
        check("rerst_overrun", 32'(overrun), 32'h0);

        // Random strobe, random ready, density switching mid-stream.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int pat = int'($urandom_range(4, 0));
            for (int i = 0; i < 500; i++) step(2, pat, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pdm_decoder.md
Name: pdm_decoder

Overview:
- Receive-side counterpart of pdm_dac: recovers DATA_BITS-wide PCM samples from a 1-bit pulse-density stream.
- Uses a 2nd-order CIC (sinc2) decimator followed by a one-entry valid/ready output register.
- Used in loopback benches to check the pdm_dac → PIN_1 path, and for PDM microphone input on the same 16 MHz clock domain.

Parameters:
- DATA_BITS, 8: output sample width. Must satisfy 1 ≤ DATA_BITS ≤ 2*DECIMATION_LOG2.
- DECIMATION_LOG2, 5: log2 of the decimation ratio R. Default R = 32, giving 500 kHz at 16 MHz with din_en tied high.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_en  input  1  PDM bit strobe; din is consumed only when high (tie to 1 for a full-rate stream).
- din  input  1  PDM bit; 1 = +full scale, 0 = zero.
- dout  output  DATA_BITS  decoded unsigned sample.
- dout_valid  output  1  dout holds an unconsumed sample.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- overrun  output  1  sticky; a sample was overwritten before being accepted.

Behaviour:
- Widths and arithmetic:
  - Internal width W = 2*DECIMATION_LOG2 + 1.
  - All integrator and comb arithmetic is modulo 2^W; wrap-around is intentional and must not saturate.
- Reset (async, rst_n low):
  - Integrators, comb delays, decimation counter and fill counter clear to 0.
  - State goes to FILL.
  - dout=0, dout_valid=0, overrun=0.
  - Asserting rst_n mid-operation discards everything in flight. The first post-reset output follows the full FILL sequence.
- Integrators (update only on din_en=1):
  - int1 <= int1 + din
  - int2 <= int2 + int1 (old int1; one-cycle registered lag)
- Decimation counter:
  - DECIMATION_LOG2 bits, increments on each din_en=1.
  - A decimation event occurs on the din_en cycle where the counter equals R-1; the counter then wraps to 0.
  - din_en=0 stalls integrators and counter with no other effect.
- Comb (on the event cycle, registered):
  - c1 = int2_next - d1, then d1 <= int2_next
  - y = c1 - d2, then d2 <= c1
  - int2_next is the value int2 takes in that same cycle.
- Scaling:
  - s = y >> (2*DECIMATION_LOG2 - DATA_BITS)
  - If s > 2^DATA_BITS - 1, clamp to 2^DATA_BITS - 1. This occurs only for all-ones input, where y = R^2.
- State machine:
  - FILL: counts decimation events and discards the first 2 after reset, then moves to RUN.
  - RUN: every event produces a sample.
  - No other states.
- Output register (timing):
  - Latency: the scaled sample appears on dout, with dout_valid=1, on the clock edge one cycle after the event cycle.
  - dout_valid clears on the cycle after acceptance, unless a new sample loads in that same cycle.
- Output register (contention):
  - New sample arrives while dout_valid=1 and dout_ready=0: overwrite dout, keep dout_valid=1, set overrun=1.
  - New sample arrives in the same cycle as acceptance: the new sample loads, dout_valid stays 1, no overrun.
- overrun clears only on reset.
- Accuracy: for a constant-density periodic input whose period divides R, every RUN sample is exact, i.e. R^2 * density, scaled and clamped.

Decomposition:
- Shared header pdm_decoder.vh, alongside the other tiny-synth .vh files, holds:
  - the CIC width function W(DECIMATION_LOG2);
  - FILL/RUN state encodings;
  - the FILL discard count (2).
- One natural sub-module: cic_sinc2_decimator. It contains the integrators, decimation counter and comb, and outputs y plus a one-cycle event strobe.
- pdm_decoder wraps it with scaling/clamp, the FILL/RUN FSM and the valid/ready register.

Test Plan:
All scenarios use defaults (R=32, DATA_BITS=8) with dout_ready tied 1 unless stated.
- Constant zeros, din_en=1: dout_valid never asserted in FILL; from the 3rd event onward dout=0x00 every 32 clocks; overrun=0.
- Constant ones: first valid output 1 clock after the 3rd event (clock 96 after reset release); dout=0xFF (1024>>2=256 clamped); stays 0xFF.
- Alternating 1,0: RUN samples all dout=0x80 (512>>2). The pattern 1,1,1,0 (75 %) gives 0xC0.
- din_en high every 4th clock with constant-ones input: events every 128 clocks; values identical to the full-rate case.
- dout_ready=0 across two events: after the 2nd event, dout holds the newer sample and overrun=1. Raising dout_ready drops dout_valid next cycle; overrun stays 1.
- rst_n pulsed low mid-window with ones input: outputs are 0 immediately (asynchronously). Two events are discarded again before 0xFF reappears; overrun=0.
